// File: rtl/vid_in_axis_ctrl.sv
// Video-input stream controller: measures frame geometry, locks after LOCK_FRAMES matching frames, and gates the stream.
// Optional vblank watchdog compiled only when VID_IN_CTRL_TIMEOUT_EN is defined.
module vid_in_axis_ctrl #(
  parameter int          CNT_W       = 12,
  parameter int          LOCK_FRAMES = 2,
  parameter logic [23:0] TIMEOUT_CYC = 24'd4000000
) (
  input  logic             aclk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             vid_vblank,
  input  logic             vid_active_video,
  input  logic             fifo_overflow,
  input  logic             clr_sticky,
  output logic             axis_enable,
  output logic             locked,
  output logic [CNT_W-1:0] frame_width,
  output logic [CNT_W-1:0] frame_height,
  output logic [1:0]       state,
  output logic             ovf_sticky,
  output logic             tmo_sticky
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    STREAM  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_FRAMES);

  state_t           state_q, state_d;
  logic [3:0]       match_cnt, match_d;
  logic             vblank_q, active_q;
  logic             vblank_rise, vblank_fall, active_fall;
  logic [CNT_W-1:0] pix_cnt, line_cnt, first_w, prev_w, prev_h;
  logic             mismatch;
  logic             frame_good;
  logic             tmo_hit;

  assign vblank_rise = vid_vblank & ~vblank_q;
  assign vblank_fall = ~vid_vblank & vblank_q;
  assign active_fall = ~vid_active_video & active_q;

  // A saturated line count can never be a valid geometry.
  assign frame_good = (line_cnt != '0) && !mismatch && (line_cnt != CNT_MAX) &&
                      (first_w == prev_w) && (line_cnt == prev_h);

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      vblank_q <= 1'b0;
      active_q <= 1'b0;
      pix_cnt  <= '0;
      line_cnt <= '0;
      first_w  <= '0;
      prev_w   <= '0;
      prev_h   <= '0;
      mismatch <= 1'b0;
    end else begin
      vblank_q <= vid_vblank;
      active_q <= vid_active_video;
      if (active_fall) begin
        pix_cnt <= '0;
        if (line_cnt == '0) first_w <= pix_cnt;
        else if (pix_cnt != first_w) mismatch <= 1'b1;
        if (pix_cnt == CNT_MAX) mismatch <= 1'b1;
        if (line_cnt != CNT_MAX) line_cnt <= line_cnt + 1'b1;
        else mismatch <= 1'b1;
      end else if (vid_active_video && (pix_cnt != CNT_MAX)) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
      // Frame close wins over a coincident line end.
      if (vblank_rise) begin
        prev_w   <= first_w;
        prev_h   <= line_cnt;
        line_cnt <= '0;
        mismatch <= 1'b0;
      end
    end
  end

`ifdef VID_IN_CTRL_TIMEOUT_EN
  logic [23:0] tmo_cnt;

  assign tmo_hit = (state_q != IDLE) && (tmo_cnt == TIMEOUT_CYC - 24'd1);

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt    <= '0;
      tmo_sticky <= 1'b0;
    end else begin
      if (vblank_rise || (state_q == IDLE) || tmo_hit) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + 24'd1;
      if (tmo_hit) tmo_sticky <= 1'b1;
      else if (clr_sticky) tmo_sticky <= 1'b0;
    end
  end
`else
  assign tmo_hit    = 1'b0;
  assign tmo_sticky = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    match_d = match_cnt;
    if (!enable) begin
      state_d = IDLE;
      match_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = MEASURE;
          match_d = '0;
        end
        MEASURE: begin
          if (vblank_rise) begin
            if (frame_good) begin
              match_d = match_cnt + 4'd1;
              if (match_d == LOCK_N) state_d = LOCKED;
            end else begin
              match_d = '0;
            end
          end
        end
        LOCKED: begin
          if (vblank_rise && !frame_good) begin
            state_d = MEASURE;
            match_d = '0;
          end else if (vblank_fall) begin
            state_d = STREAM;
          end
        end
        STREAM: begin
          if (fifo_overflow || (vblank_rise && !frame_good)) begin
            state_d = MEASURE;
            match_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
      if (tmo_hit) begin
        state_d = MEASURE;
        match_d = '0;
      end
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      match_cnt    <= '0;
      axis_enable  <= 1'b0;
      frame_width  <= '0;
      frame_height <= '0;
      ovf_sticky   <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt   <= match_d;
      axis_enable <= (state_d == STREAM);
      if ((state_q == MEASURE) && (state_d == LOCKED)) begin
        frame_width  <= first_w;
        frame_height <= line_cnt;
      end
      if (fifo_overflow) ovf_sticky <= 1'b1;
      else if (clr_sticky) ovf_sticky <= 1'b0;
    end
  end

  assign state  = state_q;
  assign locked = (state_q == LOCKED) || (state_q == STREAM);

endmodule

// File: tb/tb_vid_in_axis_ctrl.sv
// Bench for vid_in_axis_ctrl: directed scenarios plus random frames against a frame-level reference model.
module tb_vid_in_axis_ctrl;
  localparam int CNT_W       = 12;
  localparam int LOCK_FRAMES = 2;

  logic             aclk = 1'b0;
  logic             resetn = 1'b0;
  logic             enable = 1'b0;
  logic             vid_vblank = 1'b0;
  logic             vid_active_video = 1'b0;
  logic             fifo_overflow = 1'b0;
  logic             clr_sticky = 1'b0;
  logic             axis_enable, locked, ovf_sticky, tmo_sticky;
  logic [CNT_W-1:0] frame_width, frame_height;
  logic [1:0]       state;

  always #5 aclk = ~aclk;

  vid_in_axis_ctrl #(
    .CNT_W(CNT_W), .LOCK_FRAMES(LOCK_FRAMES), .TIMEOUT_CYC(24'd100)
  ) dut (
    .aclk(aclk), .resetn(resetn), .enable(enable), .vid_vblank(vid_vblank),
    .vid_active_video(vid_active_video), .fifo_overflow(fifo_overflow),
    .clr_sticky(clr_sticky), .axis_enable(axis_enable), .locked(locked),
    .frame_width(frame_width), .frame_height(frame_height), .state(state),
    .ovf_sticky(ovf_sticky), .tmo_sticky(tmo_sticky)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: frame-level view (state 0..3, lock progress, geometry)
  int m_state = 0, m_match = 0, m_fw = 0, m_fh = 0, m_prev_w = 0, m_prev_h = 0;
  bit m_ovf = 0, m_vb = 0, m_discard = 0;
  int line_q[$];
  int base_w = 8, base_h = 4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit close_frame();
    bit good;
    good = !m_discard && (line_q.size() != 0);
    foreach (line_q[i]) if (line_q[i] != line_q[0]) good = 0;
    if (line_q.size() != 0 && (line_q[0] != m_prev_w || line_q.size() != m_prev_h)) good = 0;
    if (m_discard || line_q.size() == 0) begin
      m_prev_w = -1;
      m_prev_h = -1;
    end else begin
      m_prev_w = line_q[0];
      m_prev_h = line_q.size();
    end
    m_discard = 0;
    line_q.delete();
    return good;
  endfunction

  task automatic step();
    bit rise, fall, en, ovf, clr, good;
    rise = vid_vblank && !m_vb;
    fall = !vid_vblank && m_vb;
    en = enable; ovf = fifo_overflow; clr = clr_sticky;
    good = 0;
    if (rise) good = close_frame();
    @(posedge aclk); #1;
    m_vb = vid_vblank;
    if (ovf) m_ovf = 1; else if (clr) m_ovf = 0;
    if (!en) begin
      m_state = 0; m_match = 0;
    end else begin
      case (m_state)
        0: begin m_state = 1; m_match = 0; end
        1: if (rise) begin
             if (good) begin
               m_match++;
               if (m_match == LOCK_FRAMES) begin m_state = 2; m_fw = m_prev_w; m_fh = m_prev_h; end
             end else m_match = 0;
           end
        2: if (rise && !good) begin m_state = 1; m_match = 0; end
           else if (fall) m_state = 3;
        default: if (ovf || (rise && !good)) begin m_state = 1; m_match = 0; end
      endcase
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_match = 0; m_fw = 0; m_fh = 0; m_ovf = 0; m_vb = 0; m_discard = 1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_axis"}, axis_enable, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_fw"}, frame_width, 0);
    chk({tag, "_fh"}, frame_height, 0);
    chk({tag, "_ovf"}, ovf_sticky, 0);
    chk({tag, "_tmo"}, tmo_sticky, 0);
  endtask

  task automatic run_frame(input int w, input int h, input int bad_line, input int bad_w,
                           input int en_off_line, input int rst_line, input int hb, input int vbl);
    for (int l = 0; l < h; l++) begin
      int lw;
      lw = (l == bad_line) ? bad_w : w;
      for (int c = 0; c < lw; c++) begin
        bit fall_now;
        fall_now = m_vb;
        vid_vblank = 0; vid_active_video = 1;
        if (l == en_off_line && c == 2) enable = 0;
        step();
        if (l == 0 && c == 0 && fall_now) begin
          chk("fall_state", state, m_state);
          chk("fall_axis", axis_enable, m_state == 3);
        end
        if (l == en_off_line && c == 2) begin
          chk("en_off_state", state, 0);
          chk("en_off_axis", axis_enable, 0);
          enable = 1;
        end
        if (l == rst_line && c == 2) begin
          resetn = 0; #1;
          check_all_zero("rst_mid");
          resetn = 1;
          model_reset();
        end
      end
      line_q.push_back(lw);
      vid_active_video = 0;
      for (int c = 0; c < hb; c++) step();
    end
    vid_vblank = 1;
    step();
    chk("close_state", state, m_state);
    chk("close_locked", locked, m_state >= 2);
    chk("close_axis", axis_enable, m_state == 3);
    chk("close_fw", frame_width, m_fw);
    chk("close_fh", frame_height, m_fh);
    chk("close_ovf", ovf_sticky, m_ovf);
    for (int c = 1; c < vbl; c++) step();
  endtask

  task automatic good_frame();
    run_frame(base_w, base_h, -1, 0, -1, -1, $urandom_range(2, 4), $urandom_range(2, 5));
  endtask

  task automatic to_stream();
    for (int n = 0; n < 8 && m_state != 3; n++) good_frame();
    chk("to_stream", state, 3);
  endtask

  initial begin
    resetn = 0;
    repeat (3) @(posedge aclk);
    #1;
    check_all_zero("reset");
    resetn = 1;
    step();
    chk("idle_no_en", state, 0);
    enable = 1;
    step();
    chk("en_measure", state, 1);

    // Three identical 8x4 frames lock, the fourth starts streaming
    for (int f = 0; f < 3; f++) run_frame(8, 4, -1, 0, -1, -1, 3, 4);
    chk("lock_state", state, 2);
    chk("lock_fw", frame_width, 8);
    chk("lock_fh", frame_height, 4);
    chk("lock_axis", axis_enable, 0);
    run_frame(8, 4, -1, 0, -1, -1, 3, 4);
    chk("stream_axis", axis_enable, 1);

    // Short line while streaming drops back at that frame's close
    run_frame(8, 4, 2, 7, -1, -1, 3, 4);
    chk("short_line_state", state, 1);
    chk("short_line_axis", axis_enable, 0);

    // Overflow while streaming, then overflow racing a clear
    to_stream();
    fifo_overflow = 1; step(); fifo_overflow = 0;
    chk("ovf_state", state, 1);
    chk("ovf_sticky", ovf_sticky, 1);
    fifo_overflow = 1; clr_sticky = 1; step(); fifo_overflow = 0; clr_sticky = 0;
    chk("ovf_clr_race", ovf_sticky, 1);
    clr_sticky = 1; step(); clr_sticky = 0;
    chk("clr_only", ovf_sticky, m_ovf);
    fifo_overflow = 1; step(); fifo_overflow = 0;
    chk("ovf_measure_state", state, 1);
    chk("ovf_measure_sticky", ovf_sticky, 1);

    // Random geometry: repeats, glitched lines, geometry changes
    for (int f = 0; f < 24; f++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 15) begin
        base_w = $urandom_range(3, 10);
        base_h = $urandom_range(1, 5);
        good_frame();
      end else if (r < 30) begin
        run_frame(base_w, base_h, $urandom_range(0, base_h - 1),
                  base_w + (($urandom_range(0, 1) == 1) ? 1 : -1),
                  -1, -1, $urandom_range(2, 4), $urandom_range(2, 5));
      end else begin
        good_frame();
      end
    end

    // Enable dropped mid-line while streaming
    base_w = 8; base_h = 4;
    to_stream();
    run_frame(8, 4, -1, 0, 1, -1, 3, 4);

    // Reset mid-frame while streaming; relock needs LOCK_FRAMES+1 full frames
    to_stream();
    chk("pre_rst_ovf", ovf_sticky, 1);
    run_frame(8, 4, -1, 0, -1, 1, 3, 4);
    run_frame(8, 4, -1, 0, -1, -1, 3, 4);
    chk("relock_1", state, 1);
    run_frame(8, 4, -1, 0, -1, -1, 3, 4);
    chk("relock_2", state, 1);
    run_frame(8, 4, -1, 0, -1, -1, 3, 4);
    chk("relock_3", state, 2);

    // Vblank held low while streaming
    to_stream();
    vid_vblank = 0; vid_active_video = 0;
    repeat (120) step();
`ifdef VID_IN_CTRL_TIMEOUT_EN
    chk("tmo_state", state, 1);
    chk("tmo_sticky", tmo_sticky, 1);
`else
    chk("tmo_state", state, 3);
    chk("tmo_sticky", tmo_sticky, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
